// File: rtl/eth_port_if.sv
// Byte-stream handshake bundle between eth_port and its MAC/control neighbours.
// Drop-count outputs exist only when ETH_PORT_OVF_CNT_EN is defined.
interface eth_port_if #(parameter int DEPTH_LOG2 = 4);
  logic [7:0]          i_mac_rx_data;
  logic                i_mac_rx_valid;
  logic [7:0]          o_rdata;
  logic                o_rready;
  logic                i_rreq;
  logic [7:0]          i_wdata;
  logic                i_wvalid;
  logic                o_wready;
  logic [7:0]          o_mac_tx_data;
  logic                o_mac_tx_valid;
  logic                i_mac_tx_ready;
  logic [DEPTH_LOG2:0] o_rx_level;
  logic [DEPTH_LOG2:0] o_tx_level;
  logic                o_rx_ovf;
  logic                o_tx_ovf;
`ifdef ETH_PORT_OVF_CNT_EN
  logic [15:0]         o_rx_drop_cnt;
  logic [15:0]         o_tx_drop_cnt;
`endif

  modport slave (
    input  i_mac_rx_data, i_mac_rx_valid, i_rreq, i_wdata, i_wvalid, i_mac_tx_ready,
    output o_rdata, o_rready, o_wready, o_mac_tx_data, o_mac_tx_valid,
           o_rx_level, o_tx_level, o_rx_ovf, o_tx_ovf
`ifdef ETH_PORT_OVF_CNT_EN
  , output o_rx_drop_cnt, o_tx_drop_cnt
`endif
  );

  modport master (
    output i_mac_rx_data, i_mac_rx_valid, i_rreq, i_wdata, i_wvalid, i_mac_tx_ready,
    input  o_rdata, o_rready, o_wready, o_mac_tx_data, o_mac_tx_valid,
           o_rx_level, o_tx_level, o_rx_ovf, o_tx_ovf
`ifdef ETH_PORT_OVF_CNT_EN
  , input  o_rx_drop_cnt, o_tx_drop_cnt
`endif
  );
endinterface

// File: rtl/eth_port.sv
// MAC <-> control byte bridge: independent show-ahead RX and TX FIFOs with sticky overflow.
// Optional saturating drop counters are enabled by defining ETH_PORT_OVF_CNT_EN.
module eth_port_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter bit FULL_BYPASS = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_req,
  input  logic [7:0]          push_data,
  input  logic                pop_req,
  output logic [7:0]          head,
  output logic                nonempty,
  output logic [DEPTH_LOG2:0] level,
  output logic                ovf
`ifdef ETH_PORT_OVF_CNT_EN
, output logic [15:0]         drop_cnt
`endif
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                empty, full, push, pop, drop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign nonempty = ~empty;
  assign pop      = pop_req & ~empty;
  // A full FIFO may still take a byte when it frees a slot in the same cycle (RX only).
  assign push     = push_req & (~full | (FULL_BYPASS & pop));
  assign drop     = push_req & ~push;
  assign head     = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop) ovf    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

`ifdef ETH_PORT_OVF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif
endmodule

module eth_port #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  eth_port_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  eth_port_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .FULL_BYPASS(1'b1)) u_rx (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .push_req  (bus.i_mac_rx_valid),
    .push_data (bus.i_mac_rx_data),
    .pop_req   (bus.i_rreq),
    .head      (bus.o_rdata),
    .nonempty  (bus.o_rready),
    .level     (bus.o_rx_level),
    .ovf       (bus.o_rx_ovf)
`ifdef ETH_PORT_OVF_CNT_EN
  , .drop_cnt  (bus.o_rx_drop_cnt)
`endif
  );

  eth_port_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .FULL_BYPASS(1'b0)) u_tx (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .push_req  (bus.i_wvalid),
    .push_data (bus.i_wdata),
    .pop_req   (bus.i_mac_tx_ready),
    .head      (bus.o_mac_tx_data),
    .nonempty  (bus.o_mac_tx_valid),
    .level     (bus.o_tx_level),
    .ovf       (bus.o_tx_ovf)
`ifdef ETH_PORT_OVF_CNT_EN
  , .drop_cnt  (bus.o_tx_drop_cnt)
`endif
  );

  // Derived from stored level only, so the MAC's ready never reaches o_wready.
  assign bus.o_wready = (bus.o_tx_level != (DEPTH_LOG2+1)'(DEPTH));
endmodule

// File: tb/tb_eth_port.sv
// Randomized + directed bench for eth_port against a queue-based reference model.
module tb_eth_port;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  eth_port_if #(.DEPTH_LOG2(DL)) bus ();
  eth_port #(.DEPTH_LOG2(DL)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: FIFO contents as plain queues, updated on the clock edge.
  byte unsigned rxq[$];
  byte unsigned txq[$];
  bit rx_ovf_m = 0, tx_ovf_m = 0;
  int rx_drop_m = 0, tx_drop_m = 0;
  bit rpop, rpush, tpop, tpush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rxq.delete(); txq.delete();
      rx_ovf_m = 0; tx_ovf_m = 0; rx_drop_m = 0; tx_drop_m = 0;
    end else begin
      rpop  = bus.i_rreq && rxq.size() != 0;
      rpush = bus.i_mac_rx_valid && (rxq.size() < DEPTH || rpop);
      if (bus.i_mac_rx_valid && !rpush) begin
        rx_ovf_m = 1;
        if (rx_drop_m < 65535) rx_drop_m++;
      end
      tpop  = bus.i_mac_tx_ready && txq.size() != 0;
      tpush = bus.i_wvalid && txq.size() < DEPTH;
      if (bus.i_wvalid && !tpush) begin
        tx_ovf_m = 1;
        if (tx_drop_m < 65535) tx_drop_m++;
      end
      if (rpop)  void'(rxq.pop_front());
      if (rpush) rxq.push_back(bus.i_mac_rx_data);
      if (tpop)  void'(txq.pop_front());
      if (tpush) txq.push_back(bus.i_wdata);
    end
  end

  // Monitor: compares every presented output against the model, mid-cycle.
  always @(negedge i_clk) begin
    chk("rx_rready", 32'(bus.o_rready), 32'(rxq.size() != 0));
    chk("rx_rdata",  32'(bus.o_rdata),  rxq.size() != 0 ? 32'(rxq[0]) : 32'd0);
    chk("rx_level",  32'(bus.o_rx_level), 32'(rxq.size()));
    chk("rx_ovf",    32'(bus.o_rx_ovf), 32'(rx_ovf_m));
    chk("tx_valid",  32'(bus.o_mac_tx_valid), 32'(txq.size() != 0));
    chk("tx_data",   32'(bus.o_mac_tx_data), txq.size() != 0 ? 32'(txq[0]) : 32'd0);
    chk("tx_level",  32'(bus.o_tx_level), 32'(txq.size()));
    chk("tx_wready", 32'(bus.o_wready), 32'(txq.size() < DEPTH));
    chk("tx_ovf",    32'(bus.o_tx_ovf), 32'(tx_ovf_m));
`ifdef ETH_PORT_OVF_CNT_EN
    chk("rx_drop",   32'(bus.o_rx_drop_cnt), 32'(rx_drop_m));
    chk("tx_drop",   32'(bus.o_tx_drop_cnt), 32'(tx_drop_m));
`endif
  end

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic idle();
    bus.i_mac_rx_valid = 0; bus.i_mac_rx_data = 8'h00; bus.i_rreq = 0;
    bus.i_wvalid = 0; bus.i_wdata = 8'h00; bus.i_mac_tx_ready = 0;
  endtask

  task automatic rst_pulse();
    idle();
    i_rst = 0;
    step();
    i_rst = 1;
    step();
  endtask

  byte unsigned exp_list[$];

  initial begin
    idle();
    i_rst = 0;
    step(); step();
    chk("rst_wready", 32'(bus.o_wready), 32'd1);
    chk("rst_rready", 32'(bus.o_rready), 32'd0);
    chk("rst_rdata",  32'(bus.o_rdata), 32'd0);
    i_rst = 1;
    step();

    // Three RX bytes in, three pops out.
    for (int i = 0; i < 3; i++) begin
      bus.i_mac_rx_valid = 1; bus.i_mac_rx_data = 8'(8'h11 * (i + 1));
      step();
      if (i == 0) begin
        chk("t1_rready", 32'(bus.o_rready), 32'd1);
        chk("t1_first",  32'(bus.o_rdata), 32'h11);
      end
    end
    bus.i_mac_rx_valid = 0; bus.i_rreq = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop", 32'(bus.o_rdata), 32'(8'(8'h11 * (i + 1))));
      step();
    end
    bus.i_rreq = 0;
    chk("t1_empty", 32'(bus.o_rready), 32'd0);
    chk("t1_level", 32'(bus.o_rx_level), 32'd0);

    // 17 pushes, no pops: last byte lost.
    rst_pulse();
    for (int i = 1; i <= 17; i++) begin
      bus.i_mac_rx_valid = 1; bus.i_mac_rx_data = 8'(i);
      step();
    end
    bus.i_mac_rx_valid = 0;
    chk("t2_level", 32'(bus.o_rx_level), 32'd16);
    chk("t2_ovf",   32'(bus.o_rx_ovf), 32'd1);
`ifdef ETH_PORT_OVF_CNT_EN
    chk("t2_drop",  32'(bus.o_rx_drop_cnt), 32'd1);
`endif
    bus.i_rreq = 1;
    for (int i = 1; i <= 16; i++) begin
      chk("t2_pop", 32'(bus.o_rdata), 32'(i));
      step();
    end
    bus.i_rreq = 0;

    // Full RX with simultaneous push+pop, crossing the pointer wrap.
    rst_pulse();
    for (int i = 0; i < 16; i++) begin
      bus.i_mac_rx_valid = 1; bus.i_mac_rx_data = 8'(8'h40 + i);
      step();
    end
    bus.i_rreq = 1;
    for (int i = 0; i < 5; i++) begin
      bus.i_mac_rx_data = 8'(8'h80 + i);
      chk("t3_head", 32'(bus.o_rdata), 32'(8'h40 + i));
      step();
      chk("t3_level", 32'(bus.o_rx_level), 32'd16);
    end
    bus.i_mac_rx_valid = 0;
    chk("t3_ovf", 32'(bus.o_rx_ovf), 32'd0);
    exp_list.delete();
    for (int i = 5; i < 16; i++) exp_list.push_back(8'(8'h40 + i));
    for (int i = 0; i < 5; i++)  exp_list.push_back(8'(8'h80 + i));
    for (int i = 0; i < 16; i++) begin
      chk("t3_pop", 32'(bus.o_rdata), 32'(exp_list[i]));
      step();
    end
    bus.i_rreq = 0;

    // TX: two writes held by MAC, then released.
    rst_pulse();
    bus.i_wvalid = 1; bus.i_wdata = 8'hA5; step();
    bus.i_wdata = 8'h5A; step();
    bus.i_wvalid = 0;
    chk("t4_valid", 32'(bus.o_mac_tx_valid), 32'd1);
    chk("t4_data",  32'(bus.o_mac_tx_data), 32'hA5);
    chk("t4_level", 32'(bus.o_tx_level), 32'd2);
    bus.i_mac_tx_ready = 1;
    chk("t4_d0", 32'(bus.o_mac_tx_data), 32'hA5); step();
    chk("t4_d1", 32'(bus.o_mac_tx_data), 32'h5A); step();
    chk("t4_done", 32'(bus.o_mac_tx_valid), 32'd0);
    bus.i_mac_tx_ready = 0;

    // TX fill, overflow, then async reset mid-stream.
    for (int i = 0; i < 16; i++) begin
      bus.i_wvalid = 1; bus.i_wdata = 8'(i + 1);
      bus.i_mac_rx_valid = (i < 4); bus.i_mac_rx_data = 8'(8'hC0 + i);
      step();
    end
    bus.i_mac_rx_valid = 0;
    chk("t5_wready", 32'(bus.o_wready), 32'd0);
    bus.i_wdata = 8'hEE; bus.i_mac_tx_ready = 1;
    step();
    bus.i_wvalid = 0; bus.i_mac_tx_ready = 0;
    chk("t5_ovf",   32'(bus.o_tx_ovf), 32'd1);
    chk("t5_level", 32'(bus.o_tx_level), 32'd15);
    i_rst = 0;
    #1;
    chk("t5_rst_rxl",  32'(bus.o_rx_level), 32'd0);
    chk("t5_rst_txl",  32'(bus.o_tx_level), 32'd0);
    chk("t5_rst_ovf",  32'({bus.o_rx_ovf, bus.o_tx_ovf}), 32'd0);
    chk("t5_rst_wrdy", 32'(bus.o_wready), 32'd1);
    chk("t5_rst_vld",  32'({bus.o_rready, bus.o_mac_tx_valid}), 32'd0);
    step();
    i_rst = 1;
    step();

    // Random traffic at several densities, with occasional resets.
    for (int p = 0; p < 4; p++) begin
      int pv, pr;
      pv = 30 + 20 * p;
      pr = 80 - 20 * p;
      for (int c = 0; c < 600; c++) begin
        bus.i_mac_rx_valid = ($urandom_range(99) < pv);
        bus.i_mac_rx_data  = 8'($urandom);
        bus.i_rreq         = ($urandom_range(99) < pr);
        bus.i_wvalid       = ($urandom_range(99) < pv);
        bus.i_wdata        = 8'($urandom);
        bus.i_mac_tx_ready = ($urandom_range(99) < pr);
        if ($urandom_range(299) == 0) i_rst = 0;
        step();
        i_rst = 1;
      end
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_port.md
# eth_port

Byte-stream bridge between the Ethernet MAC and the control logic, sitting at the far end of control's eth read/write interface. The RX path buffers bytes from the MAC and serves them through a show-ahead pop interface (data + ready, consumer raises request). The TX path accepts bytes from control through a ready/valid push interface and streams them to the MAC with a valid/ready handshake. Each direction has its own FIFO with overflow flagging.

## Interface
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 bytes); legal values 2..10
- i_clk  in  1  system clock; all logic is on the rising edge
- i_rst  in  1  asynchronous, active-low reset (0 = reset)
- i_mac_rx_data  in  8  received byte from the MAC
- i_mac_rx_valid  in  1  pushes i_mac_rx_data this cycle
- o_rdata  out  8  head byte of the RX FIFO (show-ahead)
- o_rready  out  1  RX FIFO non-empty
- i_rreq  in  1  pop the RX head
- i_wdata  in  8  byte from control
- i_wvalid  in  1  push i_wdata
- o_wready  out  1  TX FIFO can accept a byte
- o_mac_tx_data  out  8  head byte of the TX FIFO
- o_mac_tx_valid  out  1  TX FIFO non-empty
- i_mac_tx_ready  in  1  MAC accepts o_mac_tx_data
- o_rx_level, o_tx_level  out  DEPTH_LOG2+1  current fill counts, 0..2^DEPTH_LOG2
- o_rx_ovf, o_tx_ovf  out  1  sticky overflow flags

## Operation
- Each FIFO is a 2^DEPTH_LOG2 x 8 register array with DEPTH_LOG2+1-bit read and write pointers.
- Pointers wrap naturally modulo 2^(DEPTH_LOG2+1).
- Level = wr_ptr − rd_ptr, computed modulo that width.
- Empty = level 0. Full = level 2^DEPTH_LOG2.
- RX push: occurs when i_mac_rx_valid=1 and the FIFO is not full, or when it is full but a pop happens in the same cycle.
  - A push refused because the FIFO is full drops the byte and sets o_rx_ovf.
- RX pop: occurs when i_rreq=1 and o_rready=1. i_rreq while empty is ignored and has no side effects.
- TX push: occurs when i_wvalid=1 and o_wready=1.
  - i_wvalid while o_wready=0 drops the byte and sets o_tx_ovf.
- TX pop: occurs when o_mac_tx_valid=1 and i_mac_tx_ready=1.
- Push and pop in the same cycle leave the level unchanged. Both pointers advance.
- Overflow flags are sticky and are cleared only by reset.
- There is no state machine beyond the pointers. RX and TX are fully independent.

## Timing
- Reset values:
  - All pointers = 0.
  - o_rready=0, o_mac_tx_valid=0, o_wready=1.
  - Levels = 0, ovf flags = 0.
  - o_rdata and o_mac_tx_data = 0x00. The array is not reset, but these outputs are forced to 0 while the FIFO is empty.
- Push-to-visible latency is 1 cycle: a byte pushed at edge N appears on o_rdata / o_mac_tx_data with ready/valid high after edge N.
- Head data is a combinational read of mem[rd_ptr]. After a pop at edge N, the next byte is presented after edge N.
- o_wready = !tx_full. It is registered-state based, with no combinational path from i_mac_tx_ready.
  - Consequence: a full TX FIFO refuses a push even if the MAC pops in the same cycle.
- Reset asserted mid-transfer discards all FIFO contents immediately (asynchronous). Operation resumes on the first edge after release.

## Configuration
- ETH_PORT_OVF_CNT_EN defined:
  - Adds outputs o_rx_drop_cnt [15:0] and o_tx_drop_cnt [15:0].
  - Each counts dropped bytes, saturates at 0xFFFF, and resets to 0.
  - The sticky flags remain.
- Not defined: these ports and their counters do not exist. Only the sticky flags report overflow.

## Test plan
- Reset, then MAC pushes 0x11, 0x22, 0x33 on consecutive cycles:
  - o_rready rises after the first edge, with o_rdata=0x11.
  - Three i_rreq pops return 0x11, 0x22, 0x33.
  - o_rready falls and o_rx_level returns to 0.
- 17 RX pushes with no pops at DEPTH_LOG2=4:
  - o_rx_level=16 and o_rx_ovf=1.
  - The 17th byte is lost: the 16 pops return bytes 1..16.
  - With ETH_PORT_OVF_CNT_EN, o_rx_drop_cnt=1.
- RX full, then push and pop in the same cycle:
  - The push is accepted and the level stays 16.
  - o_rx_ovf stays 0.
  - Pop order is preserved across the pointer wrap.
- TX: control writes 0xA5, 0x5A with i_mac_tx_ready=0:
  - o_mac_tx_valid=1, o_mac_tx_data=0xA5, o_tx_level=2.
  - Raising ready delivers 0xA5 then 0x5A, then valid drops.
- TX fill to 16, then i_wvalid with data 0xEE:
  - o_wready=0, the byte is dropped and o_tx_ovf=1.
  - Assert i_rst=0 for one cycle mid-stream: levels=0, flags=0, o_wready=1, valid/ready outputs=0.
